// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider with a start/busy/done handshake.
// Produces one quotient bit per clock, MSB first, from latched copies of the operands.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      division request, taken when no division is iterating
//   dividend_i   DW-bit numerator, latched on an accepted start
//   divisor_i    VW-bit denominator, latched on an accepted start
//   busy_o       high while a division is in progress
//   done_o       one-cycle pulse when quotient/remainder become valid
//   quotient_o   DW-bit result, held until the next accepted start
//   remainder_o  VW-bit result, held until the next accepted start
//   div_zero_o   set with done when the latched divisor was zero
//
// Timing (accepting edge = edge 0, nonzero divisor):
//   edges 1..DW iterate in StRun, the FSM sits in StDone after edge DW, and the results
//   and done pulse are registered out of StDone at edge DW+1. A start seen during the
//   StDone cycle is accepted on that same edge, so back-to-back divisions are DW+1 apart.
module seq_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quotient_o,
  output logic [VW-1:0] remainder_o,
  output logic          div_zero_o
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e        state_q;
  logic [VW:0]   part_q;   // partial remainder, one spare bit for the trial shift
  logic [DW-1:0] shift_q;  // unconsumed dividend bits on the left, quotient bits enter on the right
  logic [CW-1:0] cnt_q;
  logic [VW-1:0] dvsr_q;
  logic          busy_q;
  logic          done_q;
  logic          dz_q;
  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;

  logic [VW:0]   trial;
  logic [VW:0]   diff;
  logic          ge;
  logic [VW:0]   part_d;
  logic [DW-1:0] shift_d;
  logic          accept;

  // One restoring step: shift the next dividend bit into the partial remainder and
  // subtract the divisor if it fits.
  always_comb begin
    trial   = {part_q[VW-1:0], shift_q[DW-1]};
    ge      = (trial >= {1'b0, dvsr_q});
    diff    = trial - {1'b0, dvsr_q};
    part_d  = ge ? diff : trial;
    shift_d = {shift_q[DW-2:0], ge};
  end

  assign accept = start_i && (state_q != StRun);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      part_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      dvsr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
          end
        end
        StRun: begin
          part_q  <= part_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          // Results are published here even if a new start is taken on this edge.
          done_q <= 1'b1;
          if (dvsr_q == '0) begin
            quot_q <= '1;
            rem_q  <= '1;
            dz_q   <= 1'b1;
          end else begin
            quot_q <= shift_q;
            rem_q  <= part_q[VW-1:0];
            dz_q   <= 1'b0;
          end
          if (!accept) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase

      // Operand capture overrides the per-state updates above.
      if (accept) begin
        dvsr_q  <= divisor_i;
        shift_q <= dividend_i;
        part_q  <= '0;
        cnt_q   <= CW'(DW - 1);
        busy_q  <= 1'b1;
        state_q <= (divisor_i == '0) ? StDone : StRun;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dz_q;

endmodule
